// File: rtl/fn_equiv_sweeper.sv
// rtl/fn_equiv_sweeper.sv - exhaustive equivalence sweep of original vs minimised per-lane logic
// Walks every A/B/C vector once, counting and capturing mismatches between the two paths.
module fn_equiv_sweeper #(
  parameter int NCH   = 2,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [NCH-1:0]     i_flt_mask,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [CNT_W-1:0]   o_err_cnt,
  output logic               o_fail_vld,
  output logic [3*NCH-1:0]   o_fail_vec,
  output logic [NCH-1:0]     o_f_out
);

  localparam int VW = 3 * NCH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [VW-1:0]    r_vec;
  logic [NCH-1:0]   r_mask;
  logic             r_pass;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_fail_vld;
  logic [VW-1:0]    r_fail_vec;
  logic [NCH-1:0]   r_f_out;

  logic [NCH-1:0]   w_a;
  logic [NCH-1:0]   w_b;
  logic [NCH-1:0]   w_c;
  logic [NCH-1:0]   w_fo;
  logic [NCH-1:0]   w_fm;
  logic             w_mismatch;
  logic             w_last;

  assign w_a = r_vec[NCH-1:0];
  assign w_b = r_vec[2*NCH-1:NCH];
  assign w_c = r_vec[VW-1:2*NCH];

  // Both forms are kept literally so the fault mask is the only source of divergence.
  assign w_fo       = (w_a & w_b) | (w_a & ~w_b & w_c);
  assign w_fm       = w_a & (w_b | w_c) & ~r_mask;
  assign w_mismatch = |(w_fo ^ w_fm);
  assign w_last     = &r_vec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SWEEP;
      S_SWEEP: if (w_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state == S_SWEEP);
    o_done  = (r_state == S_DONE);
    o_f_out = (r_state == S_SWEEP) ? r_f_out : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec      <= '0;
      r_mask     <= '0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_fail_vld <= 1'b0;
      r_fail_vec <= '0;
      r_f_out    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_f_out <= '0;
          if (i_start) begin
            r_vec      <= '0;
            r_mask     <= i_flt_mask;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
          end
        end
        S_SWEEP: begin
          r_vec   <= r_vec + VW'(1);
          r_f_out <= w_fm;
          if (w_mismatch) begin
            if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
            if (!r_fail_vld) begin
              r_fail_vld <= 1'b1;
              r_fail_vec <= r_vec;
            end
          end
          // The last vector's own mismatch must still veto the verdict.
          if (w_last) r_pass <= !(r_fail_vld || w_mismatch);
        end
        default: begin
          r_f_out <= '0;
        end
      endcase
    end
  end

  assign o_pass     = r_pass;
  assign o_err_cnt  = r_err_cnt;
  assign o_fail_vld = r_fail_vld;
  assign o_fail_vec = r_fail_vec;

endmodule

// File: tb/tb_fn_equiv_sweeper.sv
// tb/tb_fn_equiv_sweeper.sv - self-checking bench for fn_equiv_sweeper
module tb_fn_equiv_sweeper;

  logic       clk;
  logic       rst;
  logic       start2, start3;
  logic [1:0] mask2;
  logic [2:0] mask3;
  logic       busy2, done2, pass2, fvld2;
  logic [7:0] err2;
  logic [5:0] fvec2;
  logic [1:0] fout2;
  logic       busy3, done3, pass3, fvld3;
  logic [7:0] err3;
  logic [8:0] fvec3;
  logic [2:0] fout3;

  int checks   = 0;
  int failures = 0;

  fn_equiv_sweeper #(.NCH(2), .CNT_W(8)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_flt_mask(mask2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_cnt(err2),
    .o_fail_vld(fvld2), .o_fail_vec(fvec2), .o_f_out(fout2)
  );

  fn_equiv_sweeper #(.NCH(3), .CNT_W(8)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_flt_mask(mask3),
    .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_err_cnt(err3),
    .o_fail_vld(fvld3), .o_fail_vec(fvec3), .o_f_out(fout3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Lane bit i of the vector: A at i, B at nch+i, C at 2*nch+i.
  function automatic int lane_bit(input int v, input int pos);
    return (v >> pos) & 1;
  endfunction

  function automatic int fm_of(input int nch, input int v, input int m);
    int r = 0;
    for (int i = 0; i < nch; i++) begin
      int a = lane_bit(v, i);
      int b = lane_bit(v, nch + i);
      int c = lane_bit(v, 2 * nch + i);
      int mk = lane_bit(m, i);
      if (a == 1 && (b == 1 || c == 1) && mk == 0) r += (1 << i);
    end
    return r;
  endfunction

  function automatic int fo_of(input int nch, input int v);
    int r = 0;
    for (int i = 0; i < nch; i++) begin
      int a = lane_bit(v, i);
      int b = lane_bit(v, nch + i);
      int c = lane_bit(v, 2 * nch + i);
      if ((a == 1 && b == 1) || (a == 1 && b == 0 && c == 1)) r += (1 << i);
    end
    return r;
  endfunction

  task automatic sweep_model(input int nch, input int m, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int v = 0; v < (1 << (3 * nch)); v++) begin
      if (fo_of(nch, v) != fm_of(nch, v, m)) begin
        if (cnt == 0) first = v;
        cnt++;
      end
    end
  endtask

  task automatic check_reset2();
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_pass", pass2, 0);
    check("rst_err", err2, 0);
    check("rst_fvld", fvld2, 0);
    check("rst_fvec", fvec2, 0);
    check("rst_fout", fout2, 0);
  endtask

  task automatic run2(input int m, input bit hold);
    int cnt, first, k;
    sweep_model(2, m, cnt, first);
    @(negedge clk);
    start2 = 1'b1;
    mask2 = m[1:0];
    @(negedge clk);
    if (!hold) start2 = 1'b0;
    check("busy_rise", busy2, 1);
    check("err_clr", err2, 0);
    k = 0;
    while (busy2 === 1'b1 && k < 100) begin
      mask2 = 2'($urandom_range(0, 3));
      check("f_out", fout2, (k == 0) ? 0 : fm_of(2, k - 1, m));
      k++;
      @(negedge clk);
    end
    check("busy_cycles", k, 64);
    check("done", done2, 1);
    check("pass", pass2, (cnt == 0) ? 1 : 0);
    check("err_cnt", err2, (cnt > 255) ? 255 : cnt);
    check("fail_vld", fvld2, (cnt != 0) ? 1 : 0);
    check("fail_vec", fvec2, first);
    check("f_out_done", fout2, 0);
    @(negedge clk);
    check("done_pulse", done2, 0);
    check("idle_gap", busy2, 0);
    check("hold_err", err2, (cnt > 255) ? 255 : cnt);
    check("hold_pass", pass2, (cnt == 0) ? 1 : 0);
    check("hold_fvec", fvec2, first);
  endtask

  task automatic run3(input int m);
    int cnt, first, k;
    sweep_model(3, m, cnt, first);
    @(negedge clk);
    start3 = 1'b1;
    mask3 = m[2:0];
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    while (busy3 === 1'b1 && k < 600) begin
      mask3 = 3'($urandom_range(0, 7));
      k++;
      @(negedge clk);
    end
    check("n3_busy_cycles", k, 512);
    check("n3_done", done3, 1);
    check("n3_err_cnt", err3, (cnt > 255) ? 255 : cnt);
    check("n3_pass", pass3, (cnt == 0) ? 1 : 0);
    check("n3_fail_vld", fvld3, (cnt != 0) ? 1 : 0);
    check("n3_fail_vec", fvec3, first);
    @(negedge clk);
    check("n3_done_pulse", done3, 0);
  endtask

  initial begin
    int seen;
    int cnt, first;
    clk = 1'b0;
    rst = 1'b1;
    start2 = 1'b0;
    start3 = 1'b0;
    mask2 = '0;
    mask3 = '0;
    repeat (2) @(negedge clk);
    check_reset2();
    check("rst_busy3", busy3, 0);
    check("rst_err3", err3, 0);
    rst = 1'b0;

    sweep_model(3, 7, cnt, first);
    check("model_n3_mis", cnt, 387);

    run2(0, 1'b0);
    run2(1, 1'b0);
    run2(3, 1'b0);
    run2(2, 1'b0);

    // START held across a whole sweep: one sweep, then restart from the next IDLE.
    run2(int'($urandom_range(0, 3)), 1'b1);
    @(negedge clk);
    check("restart_from_idle", busy2, 1);
    repeat (10) @(negedge clk);
    check("abort_busy", busy2, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start2 = 1'b0;
    check_reset2();
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (done2 !== 1'b0 || busy2 !== 1'b0) seen = 1;
      @(negedge clk);
    end
    check("no_done_after_rst", seen, 0);

    rst = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start2 = 1'b0;
    check("rst_over_start", busy2, 0);

    run2(0, 1'b0);
    for (int r = 0; r < 3; r++) run2(int'($urandom_range(0, 3)), 1'b0);

    run3(7);
    run3(int'($urandom_range(0, 7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fn_equiv_sweeper.md
FN_EQUIV_SWEEPER -- requirements
Module: fn_equiv_sweeper

Interface
REQ-001 The block SHALL have parameter NCH, default 2: lane count; each of A, B, C is NCH bits.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the saturating mismatch counter.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port START  input  1  sweep request, sampled only in IDLE.
REQ-006 The block SHALL have port FLT_MASK  input  NCH  per-lane stuck-at-0 fault injection on the minimised path; captured at START acceptance.
REQ-007 The block SHALL have port BUSY  output  1  high while in SWEEP.
REQ-008 The block SHALL have port DONE  output  1  one-cycle pulse at sweep completion.
REQ-009 The block SHALL have port PASS  output  1  high when the last completed sweep had zero mismatches.
REQ-010 The block SHALL have port ERR_CNT  output  CNT_W  mismatching-vector count of the last or current sweep.
REQ-011 The block SHALL have port FAIL_VLD  output  1  high once a mismatch has been captured in the current or last sweep.
REQ-012 The block SHALL have port FAIL_VEC  output  3*NCH  first (lowest-index) mismatching vector.
REQ-013 The block SHALL have port F_OUT  output  NCH  registered minimised-path result for the vector evaluated in the previous cycle.

Function
REQ-014 Vector counter VEC SHALL be 3*NCH bits: A = VEC[NCH-1:0], B = VEC[2NCH-1:NCH], C = VEC[3NCH-1:2NCH].
REQ-015 Original path per lane i SHALL be FO[i] = A[i]B[i] + A[i]B'[i]C[i]; minimised path FM[i] = A[i](B[i]+C[i]) AND NOT FLT_MASK_q[i].
REQ-016 A vector SHALL be a mismatch when FO != FM in any lane; at most one count per vector.
REQ-017 FSM states SHALL be IDLE, SWEEP, DONE_ST.
REQ-018 IDLE with START=1 SHALL go to SWEEP next cycle: VEC=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=0, PASS=0, FLT_MASK_q=FLT_MASK.
REQ-019 SWEEP SHALL evaluate exactly one vector per cycle, VEC incrementing by 1; 2^(3*NCH) cycles total.
REQ-020 On a mismatch cycle ERR_CNT SHALL increment by 1, saturating at 2^CNT_W-1, never wrapping.
REQ-021 On the first mismatch of a sweep FAIL_VEC SHALL take VEC and FAIL_VLD SHALL set; later mismatches leave FAIL_VEC unchanged.
REQ-022 After evaluating VEC = all ones, FSM SHALL enter DONE_ST (no VEC wrap evaluation); DONE=1 for that one cycle, then IDLE.
REQ-023 In DONE_ST PASS SHALL be set to (no mismatch in sweep, including the final vector); PASS, ERR_CNT, FAIL_VLD, FAIL_VEC SHALL hold until the next accepted START or RST.
REQ-024 START in SWEEP or DONE_ST SHALL be ignored (no restart, no queuing).
REQ-025 FLT_MASK changes during SWEEP SHALL have no effect.
REQ-026 F_OUT SHALL update each SWEEP cycle with FM of current VEC (latency 1); in IDLE/DONE_ST F_OUT SHALL be 0.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, VEC=0, FLT_MASK_q=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=0, F_OUT=0.
REQ-028 RST SHALL override START and abort a sweep in progress with no DONE pulse; RST has priority over all other events in the same cycle.

Verification
REQ-029 NCH=2, FLT_MASK=0, START pulse -> BUSY high 64 cycles, DONE one cycle later, PASS=1, ERR_CNT=0, FAIL_VLD=0.
REQ-030 NCH=2, FLT_MASK=2'b01 -> ERR_CNT=24, FAIL_VLD=1, FAIL_VEC=6'd5, PASS=0.
REQ-031 NCH=2, FLT_MASK=2'b11 -> ERR_CNT=39, FAIL_VEC=6'd5, PASS=0.
REQ-032 NCH=3, CNT_W=8, FLT_MASK=3'b111 -> 387 mismatches, ERR_CNT saturates at 255, BUSY 512 cycles.
REQ-033 RST asserted on SWEEP cycle 10 -> next cycle all outputs at reset values, no DONE; new START gives full 64-cycle clean sweep.
REQ-034 START held high through sweep and DONE_ST -> exactly one sweep; a second sweep starts only if START is still high in the following IDLE cycle.
